dot_update_sequencer: RTL and testbench



---
 rtl/dot_update_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_dot_update_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_update_sequencer.sv
// dot_update_sequencer
// Holds a staging table of dot X/Y positions written by the processor and, after
// a commit, streams the whole table to the VGA controller's dot-position write
// port on the next frame boundary. Each write is held for HOLD_CYCLES clocks so
// the controller's slower pixel-clock domain can sample it.
module dot_update_sequencer #(
    parameter int NUM_DOTS    = 45,
    parameter int HOLD_CYCLES = 4,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stage_we,
    input  logic [31:0] stage_id,
    input  logic        stage_is_y,
    input  logic [31:0] stage_data,
    input  logic        commit,
    input  logic        screenEnd,
    output logic        stage_ready,
    output logic        busy,
    output logic        done,
    output logic        dotWren,
    output logic        is_Yloc,
    output logic [31:0] dotID,
    output logic [31:0] dotLoc
);

    localparam int IW = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int XW = $clog2(X_MAX + 1);
    localparam int YW = $clog2(Y_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_SEND,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   index_q, index_d;
    logic            phase_q, phase_d;   // 0 = X, 1 = Y
    logic [HW-1:0]   hold_q, hold_d;
    logic            se_q, se_d;

    logic [XW-1:0]   x_q [NUM_DOTS];
    logic [XW-1:0]   x_d [NUM_DOTS];
    logic [YW-1:0]   y_q [NUM_DOTS];
    logic [YW-1:0]   y_d [NUM_DOTS];

    logic            dot_wren_q, dot_wren_d;
    logic            is_yloc_q, is_yloc_d;
    logic [31:0]     dot_id_q, dot_id_d;
    logic [31:0]     dot_loc_q, dot_loc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            stage_ready_q, stage_ready_d;

    logic            fe;
    logic            stage_ok;
    logic [XW-1:0]   x_clamp;
    logic [YW-1:0]   y_clamp;

    assign fe       = screenEnd & ~se_q;
    assign se_d     = screenEnd;
    assign stage_ok = stage_we & stage_ready_q & (stage_id < 32'(NUM_DOTS));
    // The clamp looks at the full 32-bit value so large values never wrap into range.
    assign x_clamp  = (stage_data > 32'(X_MAX)) ? XW'(X_MAX) : stage_data[XW-1:0];
    assign y_clamp  = (stage_data > 32'(Y_MAX)) ? YW'(Y_MAX) : stage_data[YW-1:0];

    // Staging table update: accepted, clamped processor writes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        x_d = x_q;
        y_d = y_q;
        if (stage_ok) begin
            if (stage_is_y) begin
                y_d[stage_id[IW-1:0]] = y_clamp;
            end else begin
                x_d[stage_id[IW-1:0]] = x_clamp;
            end
        end
    end

    // Sequencer next state: arm on commit, start on frame edge, walk 0X,0Y,1X,... with hold windows.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        phase_d = phase_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (commit) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (fe) begin
                    state_d = S_SEND;
                    index_d = '0;
                    phase_d = 1'b0;
                    hold_d  = '0;
                end
            end
            S_SEND: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    hold_d = '0;
                    if (phase_q) begin
                        if (index_q == IW'(NUM_DOTS - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            index_d = index_q + IW'(1);
                            phase_d = 1'b0;
                        end
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs are derived from the next state so they line up with it.
    always_comb begin
        dot_wren_d    = (state_d == S_SEND);
        is_yloc_d     = dot_wren_d & phase_d;
        dot_id_d      = dot_wren_d ? 32'(index_d) : 32'd0;
        dot_loc_d     = 32'd0;
        if (dot_wren_d) begin
            dot_loc_d = phase_d ? 32'(y_d[index_d]) : 32'(x_d[index_d]);
        end
        busy_d        = (state_d == S_ARMED) || (state_d == S_SEND);
        done_d        = (state_d == S_DONE);
        stage_ready_d = (state_d == S_IDLE) || (state_d == S_ARMED);
    end

    // State, staging table and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q       <= S_IDLE;
            index_q       <= '0;
            phase_q       <= 1'b0;
            hold_q        <= '0;
            se_q          <= 1'b0;
            // NOTE: the staging table is deliberately reset; its initial contents are visible behaviour.
            for (int i = 0; i < NUM_DOTS; i++) begin
                x_q[i] <= XW'(X_INIT);
                y_q[i] <= YW'(Y_INIT);
            end
            dot_wren_q    <= 1'b0;
            is_yloc_q     <= 1'b0;
            dot_id_q      <= 32'd0;
            dot_loc_q     <= 32'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            stage_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            phase_q       <= phase_d;
            hold_q        <= hold_d;
            se_q          <= se_d;
            x_q           <= x_d;
            y_q           <= y_d;
            dot_wren_q    <= dot_wren_d;
            is_yloc_q     <= is_yloc_d;
            dot_id_q      <= dot_id_d;
            dot_loc_q     <= dot_loc_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            stage_ready_q <= stage_ready_d;
        end
    end

    assign dotWren     = dot_wren_q;
    assign is_Yloc     = is_yloc_q;
    assign dotID       = dot_id_q;
    assign dotLoc      = dot_loc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign stage_ready = stage_ready_q;

endmodule

// File: tb/tb_dot_update_sequencer.sv
// Self-checking bench for dot_update_sequencer: table-driven staging writes,
// full-stream checks against a hand-filled expectation table, and directed
// sequences for arming, coincident commit/frame edge, mid-stream reset and idle
// frame toggling.
module tb_dot_update_sequencer;

    localparam int N = 45;
    localparam int H = 4;
    localparam int STREAM_LEN = 2 * N * H;

    logic        clk = 1'b0;
    logic        reset;
    logic        stage_we;
    logic [31:0] stage_id;
    logic        stage_is_y;
    logic [31:0] stage_data;
    logic        commit;
    logic        screenEnd;
    logic        stage_ready;
    logic        busy;
    logic        done;
    logic        dotWren;
    logic        is_Yloc;
    logic [31:0] dotID;
    logic [31:0] dotLoc;

    always #5 clk = ~clk;

    dot_update_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .stage_we    (stage_we),
        .stage_id    (stage_id),
        .stage_is_y  (stage_is_y),
        .stage_data  (stage_data),
        .commit      (commit),
        .screenEnd   (screenEnd),
        .stage_ready (stage_ready),
        .busy        (busy),
        .done        (done),
        .dotWren     (dotWren),
        .is_Yloc     (is_Yloc),
        .dotID       (dotID),
        .dotLoc      (dotLoc)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int exp_x [N];
    int exp_y [N];

    typedef struct {
        logic [31:0] id;
        bit          is_y;
        logic [31:0] data;
        bit          accepted;
        int          stored;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are read 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            exp_x[i] = 320;
            exp_y[i] = 240;
        end
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " dotWren"},     32'(dotWren),     32'd0);
        check({tag, " is_Yloc"},     32'(is_Yloc),     32'd0);
        check({tag, " dotID"},       dotID,            32'd0);
        check({tag, " dotLoc"},      dotLoc,           32'd0);
        check({tag, " busy"},        32'(busy),        32'd0);
        check({tag, " done"},        32'(done),        32'd0);
        check({tag, " stage_ready"}, 32'(stage_ready), 32'd1);
    endtask

    // Expects the DUT armed with screenEnd low; raises a frame edge and checks the whole stream.
    task automatic stream_and_check(input string tag, input bit poke);
        int bad = 0;
        int done_seen = 0;
        int e_id, e_ph, e_loc;
        int got_x [N];
        int got_y [N];
        screenEnd = 1'b1;
        check({tag, " no write before edge"}, 32'(dotWren), 32'd0);
        tick();
        check({tag, " first write one cycle after edge"}, 32'(dotWren), 32'd1);
        screenEnd = 1'b0;
        for (int c = 0; c < STREAM_LEN; c++) begin
            e_id  = c / (2 * H);
            e_ph  = (c / H) % 2;
            e_loc = (e_ph != 0) ? exp_y[e_id] : exp_x[e_id];
            if (dotWren !== 1'b1 || dotID !== 32'(e_id) || 32'(is_Yloc) !== 32'(e_ph) ||
                dotLoc !== 32'(e_loc) || busy !== 1'b1 || stage_ready !== 1'b0) begin
                if (bad == 0) begin
                    $display("  %s first bad cycle %0d: wren=%0b id=%0d y=%0b loc=%0d busy=%0b rdy=%0b",
                             tag, c, dotWren, dotID, is_Yloc, dotLoc, busy, stage_ready);
                end
                bad++;
            end
            if (done === 1'b1) done_seen++;
            if (c % H == 0) begin
                if (e_ph != 0) got_y[e_id] = int'(dotLoc);
                else           got_x[e_id] = int'(dotLoc);
            end
            if (poke && c == 10) begin
                stage_we   = 1'b1;
                stage_id   = 32'd5;
                stage_is_y = 1'b0;
                stage_data = 32'd9;
            end
            tick();
            if (poke && c == 10) stage_we = 1'b0;
        end
        check({tag, " bad stream cycles"}, 32'(bad), 32'd0);
        check({tag, " done during stream"}, 32'(done_seen), 32'd0);
        check({tag, " done pulse"}, 32'(done), 32'd1);
        check({tag, " wren off in done"}, 32'(dotWren), 32'd0);
        tick();
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle stage_ready"}, 32'(stage_ready), 32'd1);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s x[%0d]", tag, i), 32'(got_x[i]), 32'(exp_x[i]));
            check($sformatf("%s y[%0d]", tag, i), 32'(got_y[i]), 32'(exp_y[i]));
        end
    endtask

    initial begin
        int cnt_a, cnt_b, cnt_c;

        // {id, is_y, data, accepted, stored} -- stored values worked out by hand.
        vecs[0]  = '{32'd3,           1'b0, 32'd100,         1'b1, 100};
        vecs[1]  = '{32'd3,           1'b1, 32'd50,          1'b1, 50};
        vecs[2]  = '{32'd0,           1'b0, 32'd1000,        1'b1, 639};
        vecs[3]  = '{32'd0,           1'b1, 32'd600,         1'b1, 479};
        vecs[4]  = '{32'd45,          1'b0, 32'd5,           1'b0, 0};
        vecs[5]  = '{32'd7,           1'b0, 32'd639,         1'b1, 639};
        vecs[6]  = '{32'd7,           1'b1, 32'd480,         1'b1, 479};
        vecs[7]  = '{32'd9,           1'b0, 32'h0001_0005,   1'b1, 639};
        vecs[8]  = '{32'd10,          1'b0, 32'd5,           1'b1, 5};
        vecs[9]  = '{32'd10,          1'b0, 32'd6,           1'b1, 6};
        vecs[10] = '{32'd44,          1'b1, 32'd0,           1'b1, 0};
        vecs[11] = '{32'h8000_0001,   1'b1, 32'd7,           1'b0, 0};

        reset      = 1'b1;
        stage_we   = 1'b0;
        stage_id   = 32'd0;
        stage_is_y = 1'b0;
        stage_data = 32'd0;
        commit     = 1'b0;
        screenEnd  = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        reset_model();
        tick();

        // Default table streams X_INIT / Y_INIT for every dot.
        pulse_commit();
        check("armed busy", 32'(busy), 32'd1);
        check("armed no wren", 32'(dotWren), 32'd0);
        check("armed stage_ready", 32'(stage_ready), 32'd1);
        stream_and_check("default", 1'b0);

        // Staging writes from the table.
        for (int v = 0; v < 12; v++) begin
            stage_we   = 1'b1;
            stage_id   = vecs[v].id;
            stage_is_y = vecs[v].is_y;
            stage_data = vecs[v].data;
            check($sformatf("vec%0d stage_ready", v), 32'(stage_ready), 32'd1);
            tick();
            stage_we = 1'b0;
            if (vecs[v].accepted) begin
                if (vecs[v].is_y) exp_y[vecs[v].id] = vecs[v].stored;
                else              exp_x[vecs[v].id] = vecs[v].stored;
            end
        end

        // Commit without a frame edge stays armed; a repeated commit changes nothing.
        pulse_commit();
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 40; i++) begin
            if (dotWren !== 1'b0) cnt_a++;
            if (busy !== 1'b1)    cnt_b++;
            commit = (i == 20);
            tick();
        end
        commit = 1'b0;
        check("armed wait wren cycles", 32'(cnt_a), 32'd0);
        check("armed wait not-busy cycles", 32'(cnt_b), 32'd0);
        stream_and_check("staged", 1'b1);

        // Commit coincident with a frame edge waits for the following edge.
        commit    = 1'b1;
        screenEnd = 1'b1;
        tick();
        commit = 1'b0;
        check("coincident busy", 32'(busy), 32'd1);
        check("coincident no wren", 32'(dotWren), 32'd0);
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            if (dotWren !== 1'b0) cnt_a++;
            tick();
        end
        screenEnd = 1'b0;
        tick();
        if (dotWren !== 1'b0) cnt_a++;
        check("coincident held level wren cycles", 32'(cnt_a), 32'd0);
        stream_and_check("coincident", 1'b0);

        // Reset in the middle of a stream.
        pulse_commit();
        screenEnd = 1'b1;
        tick();
        screenEnd = 1'b0;
        repeat (100) tick();
        check("mid-stream active", 32'(dotWren), 32'd1);
        reset = 1'b1;
        tick();
        check_reset_outputs("mid reset");
        reset = 1'b0;
        reset_model();
        tick();
        pulse_commit();
        stream_and_check("after reset", 1'b0);

        // Frame edges without a commit produce no activity.
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        for (int i = 0; i < 20; i++) begin
            screenEnd = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (k == 2) screenEnd = 1'b0;
                tick();
                if (dotWren !== 1'b0) cnt_a++;
                if (done !== 1'b0)    cnt_b++;
                if (busy !== 1'b0)    cnt_c++;
            end
        end
        check("idle toggle wren cycles", 32'(cnt_a), 32'd0);
        check("idle toggle done cycles", 32'(cnt_b), 32'd0);
        check("idle toggle busy cycles", 32'(cnt_c), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
